// File: rtl/dac_interp.sv
// Linear-interpolating upsampler: strobed input samples in, 2^INTERP_NBIT
// evenly spaced output samples per input interval, one every TICK_DIV clocks.
// Late input is concealed by repeating the last sample (underrun).
module dac_interp #(
  parameter int DATA_NBIT   = 12,
  parameter int INTERP_NBIT = 2,
  parameter int TICK_DIV    = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_strobe,
  input  logic [DATA_NBIT-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_strobe,
  output logic [DATA_NBIT-1:0] o_data,
  output logic                 o_underrun,
  output logic                 o_overflow
);

  localparam int ACC_W = DATA_NBIT + INTERP_NBIT + 1;
  localparam int TW    = $clog2(TICK_DIV);
  localparam logic [TW-1:0]          TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [INTERP_NBIT-1:0] K_LAST    = '1;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT2, S_RUN, S_HOLD} state_t;

  state_t                   state_q, state_d;
  logic [DATA_NBIT-1:0]     p_q, p_d, c_q, c_d, smp_buf_q, smp_buf_d;
  logic                     buf_valid_q, buf_valid_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [INTERP_NBIT-1:0]   k_q, k_d;
  logic [TW-1:0]            tick_q, tick_d;
  logic [DATA_NBIT-1:0]     o_data_q, o_data_d;
  logic                     o_strobe_q, o_strobe_d;
  logic                     o_underrun_q, o_underrun_d;
  logic                     o_overflow_q, o_overflow_d;

  // Segment arithmetic: delta of the running segment, delta of a segment that
  // would start from c toward the buffered sample, and c scaled to acc units.
  logic signed [DATA_NBIT:0] d_run, d_new;
  logic signed [ACC_W-1:0]   d_run_x, d_new_x, c_shl, acc_shr;
  logic                      tick_wrap;

  assign d_run     = $signed({1'b0, c_q}) - $signed({1'b0, p_q});
  assign d_new     = $signed({1'b0, smp_buf_q}) - $signed({1'b0, c_q});
  assign d_run_x   = {{(ACC_W-DATA_NBIT-1){d_run[DATA_NBIT]}}, d_run};
  assign d_new_x   = {{(ACC_W-DATA_NBIT-1){d_new[DATA_NBIT]}}, d_new};
  assign c_shl     = $signed({1'b0, c_q, {INTERP_NBIT{1'b0}}});
  assign acc_shr   = acc_q >>> INTERP_NBIT;
  assign tick_wrap = (tick_q == TICK_LAST);

  assign o_ready    = !buf_valid_q;
  assign o_strobe   = o_strobe_q;
  assign o_data     = o_data_q;
  assign o_underrun = o_underrun_q;
  assign o_overflow = o_overflow_q;

  // Next-state: input buffering, segment sequencing and output emission.
  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    c_d          = c_q;
    smp_buf_d    = smp_buf_q;
    buf_valid_d  = buf_valid_q;
    acc_d        = acc_q;
    k_d          = k_q;
    tick_d       = tick_q;
    o_data_d     = o_data_q;
    o_strobe_d   = 1'b0;
    o_underrun_d = 1'b0;
    // A strobe while the buffer is full is dropped; draining only ever
    // happens while full, so a same-cycle strobe is never accepted.
    o_overflow_d = i_strobe & buf_valid_q;
    if (i_strobe && !buf_valid_q) begin
      smp_buf_d   = i_data;
      buf_valid_d = 1'b1;
    end

    case (state_q)
      S_EMPTY: begin
        if (buf_valid_q) begin
          c_d         = smp_buf_q;
          buf_valid_d = 1'b0;
          state_d     = S_WAIT2;
        end
      end
      S_WAIT2: begin
        if (buf_valid_q) begin
          p_d         = c_q;
          c_d         = smp_buf_q;
          acc_d       = c_shl;
          k_d         = '0;
          tick_d      = '0;
          buf_valid_d = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        if (tick_wrap) begin
          o_strobe_d = 1'b1;
          o_data_d   = acc_shr[DATA_NBIT-1:0];
          acc_d      = acc_q + d_run_x;
          k_d        = k_q + INTERP_NBIT'(1);
          if (k_q == K_LAST) begin
            if (buf_valid_q) begin
              p_d         = c_q;
              c_d         = smp_buf_q;
              acc_d       = c_shl;
              k_d         = '0;
              buf_valid_d = 1'b0;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
      end
      default: begin // S_HOLD
        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        if (tick_wrap) begin
          o_strobe_d = 1'b1;
          o_data_d   = c_q;
          if (buf_valid_q) begin
            // This tick already emits c as step 0 of the new segment, so the
            // accumulator is pre-advanced to step 1.
            p_d         = c_q;
            c_d         = smp_buf_q;
            acc_d       = c_shl + d_new_x;
            k_d         = INTERP_NBIT'(1);
            buf_valid_d = 1'b0;
            state_d     = S_RUN;
          end else begin
            o_underrun_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      p_q          <= '0;
      c_q          <= '0;
      smp_buf_q    <= '0;
      buf_valid_q  <= 1'b0;
      acc_q        <= '0;
      k_q          <= '0;
      tick_q       <= '0;
      o_data_q     <= '0;
      o_strobe_q   <= 1'b0;
      o_underrun_q <= 1'b0;
      o_overflow_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      c_q          <= c_d;
      smp_buf_q    <= smp_buf_d;
      buf_valid_q  <= buf_valid_d;
      acc_q        <= acc_d;
      k_q          <= k_d;
      tick_q       <= tick_d;
      o_data_q     <= o_data_d;
      o_strobe_q   <= o_strobe_d;
      o_underrun_q <= o_underrun_d;
      o_overflow_q <= o_overflow_d;
    end
  end

endmodule

// File: tb/tb_dac_interp.sv
// Scoreboard bench for dac_interp: a sample-level reference model predicts
// output values/flags, a negedge monitor compares against the DUT.
module tb_dac_interp;
  localparam int DW = 12, IN = 2, TD = 4, N = 1 << IN;

  logic          clk = 0, rst = 1, i_strobe = 0;
  logic [DW-1:0] i_data = '0;
  logic          o_ready, o_strobe, o_underrun, o_overflow;
  logic [DW-1:0] o_data;

  dac_interp #(.DATA_NBIT(DW), .INTERP_NBIT(IN), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .i_strobe(i_strobe), .i_data(i_data),
    .o_ready(o_ready), .o_strobe(o_strobe), .o_data(o_data),
    .o_underrun(o_underrun), .o_overflow(o_overflow));

  always #5 clk = ~clk;

  typedef struct { int data; bit und; } exp_t;
  exp_t sb[$];
  int   obs[$];
  int   checks = 0, errors = 0, ovf_seen = 0;

  // Reference model state: samples held, pending segment values, tick timer.
  int   mstate = 0, mc = 0, mbuf = 0, cnt = 0;
  bit   mbv = 0, m_strb = 0, m_ovf = 0, rdy;
  int   seg[$];
  exp_t e;

  // Point k of N on the line p->c, rounded toward minus infinity.
  function automatic int interp(int p, int c, int k);
    int num = k * (c - p);
    if (num >= 0) return p + num / N;
    return p - ((-num + N - 1) / N);
  endfunction

  function automatic void new_seg(int p, int c);
    seg.delete();
    for (int k = 0; k < N; k++) seg.push_back(interp(p, c, k));
  endfunction

  function automatic void push_exp(int v, bit u);
    exp_t x;
    x.data = v; x.und = u;
    sb.push_back(x);
    m_strb = 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mstate = 0; mc = 0; mbuf = 0; mbv = 0; cnt = 0;
      m_strb = 0; m_ovf = 0;
      seg.delete(); sb.delete();
    end else begin
      rdy = !mbv; m_strb = 0; m_ovf = 0;
      if (mstate == 0) begin
        if (mbv) begin mc = mbuf; mbv = 0; mstate = 1; end
      end else if (mstate == 1) begin
        if (mbv) begin
          new_seg(mc, mbuf); mc = mbuf; mbv = 0; mstate = 2; cnt = TD;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          cnt = TD;
          if (seg.size() != 0) begin
            push_exp(seg.pop_front(), 0);
            if (seg.size() == 0 && mbv) begin
              new_seg(mc, mbuf); mc = mbuf; mbv = 0;
            end
          end else if (mbv) begin
            new_seg(mc, mbuf); mc = mbuf; mbv = 0;
            push_exp(seg.pop_front(), 0);
          end else begin
            push_exp(mc, 1);
          end
        end
      end
      if (i_strobe) begin
        if (rdy) begin mbuf = int'(i_data); mbv = 1; end
        else m_ovf = 1;
      end
    end
  end

  logic [DW-1:0] last_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ({o_strobe, o_underrun, o_overflow, o_ready} !== 4'b0001 || o_data !== '0) begin
        errors++;
        $display("FAIL reset_hold got s/u/o/r=%b%b%b%b data=%0d required 0001 data=0",
                 o_strobe, o_underrun, o_overflow, o_ready, o_data);
      end
      last_data = '0;
    end else begin
      checks++;
      if (o_strobe !== m_strb) begin
        errors++; $display("FAIL strobe_timing got %b required %b at %0t", o_strobe, m_strb, $time);
      end
      checks++;
      if (o_overflow !== m_ovf) begin
        errors++; $display("FAIL overflow got %b required %b at %0t", o_overflow, m_ovf, $time);
      end
      checks++;
      if (o_ready !== !mbv) begin
        errors++; $display("FAIL ready got %b required %b at %0t", o_ready, !mbv, $time);
      end
      if (o_overflow) ovf_seen++;
      if (o_strobe) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL unexpected_strobe got data=%0d required no strobe", o_data);
        end else begin
          e = sb.pop_front();
          if (int'(o_data) != e.data || o_underrun !== e.und) begin
            errors++;
            $display("FAIL sample got data=%0d und=%b required data=%0d und=%b at %0t",
                     o_data, o_underrun, e.data, e.und, $time);
          end
        end
        obs.push_back(int'(o_data));
        last_data = o_data;
      end else begin
        checks++;
        if (o_underrun !== 1'b0 || o_data !== last_data) begin
          errors++;
          $display("FAIL idle_stable got und=%b data=%0d required und=0 data=%0d",
                   o_underrun, o_data, last_data);
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++; $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic send(int v);
    @(negedge clk); i_strobe = 1; i_data = DW'(v);
    @(negedge clk); i_strobe = 0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk); #2 rst = 1;
    #1 chk("async_reset_outs", int'({o_strobe, o_underrun, o_overflow, o_ready, o_data}),
           int'({4'b0001, 12'd0}));
    @(posedge clk); #2 rst = 0;
  endtask

  task automatic chk_obs(string name, int base, int v0, int v1, int v2, int v3);
    checks++;
    if (obs.size() < base + 4) begin
      errors++; $display("FAIL %s got %0d outputs required at least %0d", name, obs.size(), base + 4);
    end else if (obs[base] != v0 || obs[base+1] != v1 || obs[base+2] != v2 || obs[base+3] != v3) begin
      errors++;
      $display("FAIL %s got %0d %0d %0d %0d required %0d %0d %0d %0d", name,
               obs[base], obs[base+1], obs[base+2], obs[base+3], v0, v1, v2, v3);
    end
  endtask

  initial begin
    int idx;
    idle(2);
    @(posedge clk); #2 rst = 0;

    // Rising ramp then hold.
    obs.delete();
    send(100); send(200); idle(30);
    chk_obs("rising_ramp", 0, 100, 125, 150, 175);
    chk("hold_value", obs.size() > 4 ? obs[4] : -1, 200);

    // Recovery from hold with a new sample.
    obs.delete();
    send(1000); idle(30);
    idx = -1;
    for (int i = 1; i < obs.size(); i++) if (idx < 0 && obs[i] == 400) idx = i;
    checks++;
    if (idx < 1 || idx + 2 >= obs.size() || obs[idx-1] != 200 || obs[idx+1] != 600 || obs[idx+2] != 800) begin
      errors++; $display("FAIL hold_recovery got index %0d required 200,400,600,800 run", idx);
    end

    // Floor rounding both directions.
    do_reset(); obs.delete();
    send(3); send(0); idle(24);
    chk_obs("falling_floor", 0, 3, 2, 1, 0);
    do_reset(); obs.delete();
    send(0); send(3); idle(24);
    chk_obs("rising_floor", 0, 0, 0, 1, 2);

    // Seamless stream across a segment boundary.
    do_reset(); obs.delete();
    send(0); send(400); idle(14); send(800); idle(30);
    chk_obs("stream_seg1", 0, 0, 100, 200, 300);
    chk_obs("stream_seg2", 4, 400, 500, 600, 700);
    chk("stream_hold", obs.size() > 8 ? obs[8] : -1, 800);

    // Overflow: fourth sample lands while the buffer is full.
    do_reset(); obs.delete(); ovf_seen = 0;
    send(10); send(20); send(30); send(40); idle(40);
    chk("overflow_pulses", ovf_seen, 1);
    chk_obs("overflow_next_seg", 4, 20, 22, 25, 27);

    // Reset mid-RUN: one sample afterwards must not start output.
    do_reset(); obs.delete();
    send(500); send(900); idle(6);
    do_reset(); obs.delete();
    send(7); idle(40);
    chk("single_after_reset", obs.size(), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      send(int'($urandom_range(0, 4095)));
      idle(int'($urandom_range(0, 20)));
    end
    idle(60);
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
